// File: rtl/nbody_pkg.sv
// Shared constants and state encoding for the n-body step sequencer.
// Latencies describe the datapath this block schedules around: the getAccl
// pipeline, the AddSub units and the body RAMs.
package nbody_pkg;

    // Datapath latencies in clock cycles.
    localparam int ACCL_LATENCY = 123;
    localparam int ADD_LATENCY  = 20;
    localparam int RAM_LATENCY  = 1;

    // An inner sweep must be at least one AddSub pass long, so a velocity
    // write to v[i] lands before the next read of v[i] is issued.
    localparam int MIN_SWEEP    = ADD_LATENCY + 1;

    // Tail of each phase, waiting for the last issued item to be written back.
    localparam int DRAIN_A_LEN  = ACCL_LATENCY + ADD_LATENCY;
    localparam int DRAIN_P_LEN  = RAM_LATENCY + ADD_LATENCY;

    // Strobe alignment delays, measured from the issue strobe.
    localparam int VRD_DELAY    = ACCL_LATENCY - RAM_LATENCY;
    localparam int VWR_DELAY    = ACCL_LATENCY + ADD_LATENCY;
    localparam int PWR_DELAY    = RAM_LATENCY + ADD_LATENCY;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEL   = 3'd1,
        DRAIN_A = 3'd2,
        POS     = 3'd3,
        DRAIN_P = 3'd4,
        DONE    = 3'd5
    } phase_t;

    // Coarse phase code seen by the bus wrapper: 0 idle, 1 accel, 2 pos, 3 done.
    function automatic logic [1:0] phase_code(input phase_t s);
        logic [1:0] c;
        c = 2'd0;
        case (s)
            ACCEL, DRAIN_A: c = 2'd1;
            POS, DRAIN_P:   c = 2'd2;
            DONE:           c = 2'd3;
            default:        c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nbody_tag_delay.sv
// Fixed-depth delay line for a {valid, address} tag. Used to line up RAM
// strobes with the datapath latency. A synchronous clear empties the whole
// line in one cycle so nothing in flight survives a reset or abort.
module nbody_tag_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_addr
);

    logic             valid_q [DEPTH];
    logic [WIDTH-1:0] addr_q  [DEPTH];

    // Shift one stage per cycle; clear drops every stage at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < DEPTH; s++) begin
                valid_q[s] <= 1'b0;
                addr_q[s]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                addr_q[s]  <= addr_q[s-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/nbody_step_sched.sv
// Step sequencer for the n-body datapath.
// Each step runs an acceleration phase (all (i,j) pairs, j outer / i inner,
// sweeps padded with bubbles to at least MIN_SWEEP cycles so read-modify-write
// of v[i] never overlaps), drains the pipeline, then a position phase (one
// body per cycle) and its drain. Velocity and position RAM strobes are the
// issue strobes passed through fixed delay lines.
//
// Handshake toward the bus wrapper: start is a one-cycle pulse honoured only
// in IDLE; done rises at run end and stays high until a one-cycle ack pulse;
// abort returns to IDLE from any state and flushes every in-flight strobe.
module nbody_step_sched
    import nbody_pkg::*;
#(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int STEP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ack,
    input  logic                       abort,
    input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
    input  logic [STEP_WIDTH-1:0]      num_steps,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 phase,
    output logic                       first_step,
    output logic                       pair_valid,
    output logic [BODY_ADDR_WIDTH-1:0] pair_i,
    output logic [BODY_ADDR_WIDTH-1:0] pair_j,
    output logic                       pair_self,
    output logic                       vrd_valid,
    output logic [BODY_ADDR_WIDTH-1:0] vrd_addr,
    output logic                       vwr_valid,
    output logic [BODY_ADDR_WIDTH-1:0] vwr_addr,
    output logic                       pos_valid,
    output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
    output logic                       pwr_valid,
    output logic [BODY_ADDR_WIDTH-1:0] pwr_addr,
    output phase_t                     dbg_state
);

    localparam int AW = BODY_ADDR_WIDTH;
    localparam int CW = BODY_ADDR_WIDTH + 1;
    localparam int DW = $clog2(DRAIN_A_LEN + 1);

    localparam logic [CW-1:0] MIN_SWEEP_C = CW'(MIN_SWEEP);
    localparam logic [DW-1:0] DRAIN_A_END = DW'(DRAIN_A_LEN - 1);
    localparam logic [DW-1:0] DRAIN_P_END = DW'(DRAIN_P_LEN - 1);

    phase_t                state_q;
    logic [CW-1:0]         n_q;          // latched body count
    logic [STEP_WIDTH-1:0] steps_q;      // latched step count
    logic [STEP_WIDTH-1:0] step_cnt_q;
    logic [STEP_WIDTH-1:0] step_cnt_d;
    logic [CW-1:0]         sweep_q;      // inner-sweep position: i, then bubbles
    logic [AW-1:0]         j_q;
    logic [AW-1:0]         k_q;          // position-phase body index
    logic [DW-1:0]         drain_q;
    logic                  first_q;

    logic [CW-1:0]         sweep_last;
    logic [CW-1:0]         n_last;
    logic                  clr;

    // Sweep length is max(n, MIN_SWEEP); small systems get bubble padding.
    assign sweep_last = ((n_q > MIN_SWEEP_C) ? n_q : MIN_SWEEP_C) - CW'(1);
    assign n_last     = n_q - CW'(1);
    assign step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
    assign clr        = rst | abort;

    // Sequencer: phase transitions, issue counters and config latch.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            n_q        <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            sweep_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            first_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q        <= num_bodies;
                        steps_q    <= num_steps;
                        step_cnt_q <= '0;
                        sweep_q    <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        drain_q    <= '0;
                        first_q    <= 1'b1;
                        if ((num_bodies <= CW'(1)) || (num_steps == '0)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCEL;
                        end
                    end
                end
                ACCEL: begin
                    if (sweep_q == sweep_last) begin
                        sweep_q <= '0;
                        if ({1'b0, j_q} == n_last) begin
                            j_q     <= '0;
                            drain_q <= '0;
                            state_q <= DRAIN_A;
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end else begin
                        sweep_q <= sweep_q + CW'(1);
                    end
                end
                DRAIN_A: begin
                    if (drain_q == DRAIN_A_END) begin
                        drain_q <= '0;
                        k_q     <= '0;
                        state_q <= POS;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                POS: begin
                    if ({1'b0, k_q} == n_last) begin
                        k_q     <= '0;
                        drain_q <= '0;
                        state_q <= DRAIN_P;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                DRAIN_P: begin
                    if (drain_q == DRAIN_P_END) begin
                        drain_q    <= '0;
                        step_cnt_q <= step_cnt_d;
                        first_q    <= 1'b0;
                        if (step_cnt_d == steps_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCEL;
                        end
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                        first_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Issue strobes decoded from state; addresses read as 0 when not valid.
    assign pair_valid  = (state_q == ACCEL) && (sweep_q < n_q);
    assign pair_i      = pair_valid ? sweep_q[AW-1:0] : '0;
    assign pair_j      = pair_valid ? j_q : '0;
    assign pair_self   = pair_valid && (sweep_q == {1'b0, j_q});
    assign pos_valid   = (state_q == POS);
    assign pos_rd_addr = pos_valid ? k_q : '0;

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign phase       = phase_code(state_q);
    assign first_step  = first_q && busy;
    assign dbg_state   = state_q;

    // Velocity read lands one RAM latency ahead of ax/ay.
    nbody_tag_delay #(.DEPTH(VRD_DELAY), .WIDTH(AW)) u_vrd_dly (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (pair_valid),
        .in_addr   (pair_i),
        .out_valid (vrd_valid),
        .out_addr  (vrd_addr)
    );

    // Velocity write follows the accel pipeline and one AddSub pass.
    nbody_tag_delay #(.DEPTH(VWR_DELAY), .WIDTH(AW)) u_vwr_dly (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (pair_valid),
        .in_addr   (pair_i),
        .out_valid (vwr_valid),
        .out_addr  (vwr_addr)
    );

    // Position write follows the RAM read and one AddSub pass.
    nbody_tag_delay #(.DEPTH(PWR_DELAY), .WIDTH(AW)) u_pwr_dly (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (pos_valid),
        .in_addr   (pos_rd_addr),
        .out_valid (pwr_valid),
        .out_addr  (pwr_addr)
    );

endmodule

// File: tb/tb_nbody_step_sched.sv
// Directed bench for the n-body step sequencer: timing of a full run,
// pair ordering, strobe alignment, hazard spacing, handshake, abort and reset.
module tb_nbody_step_sched;
  import nbody_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, start, ack, abort;
  logic [9:0]  num_bodies;
  logic [15:0] num_steps;
  logic        busy, done, first_step, pair_valid, pair_self;
  logic [1:0]  phase;
  logic [8:0]  pair_i, pair_j;
  logic        vrd_valid, vwr_valid, pos_valid, pwr_valid;
  logic [8:0]  vrd_addr, vwr_addr, pos_rd_addr, pwr_addr;
  phase_t      dbg_state;

  always #5 clk = ~clk;

  nbody_step_sched dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .abort(abort),
    .num_bodies(num_bodies), .num_steps(num_steps),
    .busy(busy), .done(done), .phase(phase), .first_step(first_step),
    .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j), .pair_self(pair_self),
    .vrd_valid(vrd_valid), .vrd_addr(vrd_addr),
    .vwr_valid(vwr_valid), .vwr_addr(vwr_addr),
    .pos_valid(pos_valid), .pos_rd_addr(pos_rd_addr),
    .pwr_valid(pwr_valid), .pwr_addr(pwr_addr),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pair_cnt, self_cnt, vrd_cnt, vwr_cnt, pos_cnt, pwr_cnt, any_valid_cnt;
  int bubble_cnt, first_cnt, order_err, vrd_align_err, vwr_align_err, pwr_align_err;
  int hazard_err, mutex_err;
  int exp_pi, exp_pj, n_cur;
  int last_wr [512];
  logic [9:0] vrd_exp_q[$];
  logic [9:0] vwr_exp_q[$];
  logic [9:0] pwr_exp_q[$];
  logic [9:0] front;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Monitor: counts strobes and compares each delayed strobe with the issue
  // stream recorded the required number of cycles earlier.
  always @(negedge clk) begin
    cyc++;
    if (pair_valid) begin
      pair_cnt++;
      if (pair_i != 9'(exp_pi) || pair_j != 9'(exp_pj)) order_err++;
      if (exp_pi == n_cur - 1) begin
        exp_pi = 0;
        exp_pj = (exp_pj == n_cur - 1) ? 0 : exp_pj + 1;
      end else begin
        exp_pi++;
      end
    end
    if (pair_self) self_cnt++;
    if (dbg_state == ACCEL && !pair_valid) bubble_cnt++;
    if (vrd_valid) vrd_cnt++;
    if (vwr_valid) vwr_cnt++;
    if (pos_valid) pos_cnt++;
    if (pwr_valid) pwr_cnt++;
    if (pair_valid | vrd_valid | vwr_valid | pos_valid | pwr_valid | pair_self) any_valid_cnt++;
    if (first_step) first_cnt++;
    if ((pos_valid | pwr_valid) & (pair_valid | vwr_valid)) mutex_err++;
    if (vwr_valid) begin
      if (cyc - last_wr[vwr_addr] < MIN_SWEEP) hazard_err++;
      last_wr[vwr_addr] = cyc;
    end
    vrd_exp_q.push_back({pair_valid, pair_i});
    vwr_exp_q.push_back({pair_valid, pair_i});
    pwr_exp_q.push_back({pos_valid, pos_rd_addr});
    if (vrd_exp_q.size() > VRD_DELAY) begin
      front = vrd_exp_q.pop_front();
      if (front != {vrd_valid, vrd_addr}) vrd_align_err++;
    end
    if (vwr_exp_q.size() > VWR_DELAY) begin
      front = vwr_exp_q.pop_front();
      if (front != {vwr_valid, vwr_addr}) vwr_align_err++;
    end
    if (pwr_exp_q.size() > PWR_DELAY) begin
      front = pwr_exp_q.pop_front();
      if (front != {pwr_valid, pwr_addr}) pwr_align_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats(input int n);
    @(negedge clk);
    #1;
    pair_cnt = 0; self_cnt = 0; vrd_cnt = 0; vwr_cnt = 0; pos_cnt = 0; pwr_cnt = 0;
    any_valid_cnt = 0; bubble_cnt = 0; first_cnt = 0; order_err = 0;
    vrd_align_err = 0; vwr_align_err = 0; pwr_align_err = 0; hazard_err = 0; mutex_err = 0;
    exp_pi = 0; exp_pj = 0; n_cur = n;
    for (int a = 0; a < 512; a++) last_wr[a] = -1000;
    vrd_exp_q.delete();
    vwr_exp_q.delete();
    pwr_exp_q.delete();
  endtask

  // Start pulse sampled at edge 0; returns in cycle 1 (negedge after edge 0).
  task automatic start_run(input int n, input int s);
    clear_stats(n);
    num_bodies = 10'(n);
    num_steps  = 16'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int l);
    l = 1;
    while (!done && l < limit) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  function automatic logic all_out_zero();
    return ({busy, done, phase, first_step, pair_valid, pair_i, pair_j, pair_self,
             vrd_valid, vrd_addr, vwr_valid, vwr_addr, pos_valid, pos_rd_addr,
             pwr_valid, pwr_addr} == '0);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
    num_bodies = '0; num_steps = '0;
    n_cur = 1; exp_pi = 0; exp_pj = 0;
    for (int a = 0; a < 512; a++) last_wr[a] = -1000;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 32'(all_out_zero()), 1);
    check("reset_state_idle", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: n=4, one step.
    start_run(4, 1);
    check("s1_first_step_accel", 32'(first_step), 1);
    check("s1_phase_accel", 32'(phase), 1);
    wait_done(400, lat);
    check("s1_done_cycle", lat, 253);
    check("s1_pair_count", pair_cnt, 16);
    check("s1_bubbles", bubble_cnt, 68);
    check("s1_self_count", self_cnt, 4);
    check("s1_pair_order", order_err, 0);
    check("s1_vrd_count", vrd_cnt, 16);
    check("s1_vwr_count", vwr_cnt, 16);
    check("s1_pos_count", pos_cnt, 4);
    check("s1_pwr_count", pwr_cnt, 4);
    check("s1_vrd_align", vrd_align_err, 0);
    check("s1_vwr_align", vwr_align_err, 0);
    check("s1_pwr_align", pwr_align_err, 0);
    check("s1_mutex", mutex_err, 0);
    check("s1_phase_done", 32'(phase), 3);
    check("s1_busy_done", 32'(busy), 0);
    check("s1_first_step_done", 32'(first_step), 0);

    // Handshake: done holds without ack; start in DONE ignored; ack clears.
    repeat (100) @(negedge clk);
    check("hs_done_held", 32'(done), 1);
    num_bodies = 10'd4; num_steps = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs_start_in_done_ignored", 32'(phase), 3);
    check("hs_done_still", 32'(done), 1);
    pulse_ack;
    check("hs_ack_done_low", 32'(done), 0);
    check("hs_ack_idle", 32'(phase), 0);

    // Scenario 2: n=32, two steps, no bubbles.
    start_run(32, 2);
    wait_done(3000, lat);
    check("s2_done_cycle", lat, 2441);
    check("s2_pair_count", pair_cnt, 2048);
    check("s2_bubbles", bubble_cnt, 0);
    check("s2_self_count", self_cnt, 64);
    check("s2_vwr_count", vwr_cnt, 2048);
    check("s2_vrd_count", vrd_cnt, 2048);
    check("s2_pwr_count", pwr_cnt, 64);
    check("s2_first_step_cycles", first_cnt, 1220);
    check("s2_pair_order", order_err, 0);
    check("s2_vwr_align", vwr_align_err, 0);
    check("s2_vrd_align", vrd_align_err, 0);
    check("s2_pwr_align", pwr_align_err, 0);
    check("s2_vwr_hazard", hazard_err, 0);
    check("s2_mutex", mutex_err, 0);

    // ack together with abort in DONE returns to IDLE.
    ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    ack = 1'b0; abort = 1'b0;
    check("ack_abort_idle", 32'(dbg_state), 32'(IDLE));
    check("ack_abort_done_low", 32'(done), 0);

    // Scenario 4: degenerate runs finish immediately.
    start_run(1, 5);
    check("s4_n1_done_next", 32'(done), 1);
    check("s4_n1_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("s4_n1_no_strobes", any_valid_cnt, 0);
    pulse_ack;
    start_run(4, 0);
    check("s4_s0_done_next", 32'(done), 1);
    repeat (5) @(negedge clk);
    check("s4_s0_no_strobes", any_valid_cnt, 0);
    pulse_ack;

    // start together with abort in IDLE: abort wins.
    @(negedge clk);
    num_bodies = 10'd4; num_steps = 16'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("start_abort_stays_idle", 32'(busy), 0);

    // Scenario 5: abort 50 cycles into DRAIN_A.
    start_run(4, 1);
    repeat (134) @(negedge clk);
    check("s5_in_drain_a", 32'(dbg_state), 32'(DRAIN_A));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s5_abort_idle", 32'(dbg_state), 32'(IDLE));
    check("s5_abort_outputs_zero", 32'(all_out_zero()), 1);
    clear_stats(4);
    repeat (200) @(negedge clk);
    check("s5_no_vwr_after_abort", vwr_cnt, 0);
    check("s5_no_pwr_after_abort", pwr_cnt, 0);
    start_run(4, 1);
    wait_done(400, lat);
    check("s5_rerun_done_cycle", lat, 253);
    check("s5_rerun_vwr_count", vwr_cnt, 16);
    check("s5_rerun_vwr_align", vwr_align_err, 0);
    pulse_ack;

    // Scenario 3 (partial): n=BODIES, first sweep reaches i=511 then j advances.
    start_run(512, 1);
    repeat (511) @(negedge clk);
    check("s3_i511_valid", 32'(pair_valid), 1);
    check("s3_i511", 32'(pair_i), 511);
    check("s3_j0", 32'(pair_j), 0);
    @(negedge clk);
    check("s3_wrap_i", 32'(pair_i), 0);
    check("s3_wrap_j", 32'(pair_j), 1);
    check("s3_no_bubbles", bubble_cnt, 0);
    check("s3_pair_order", order_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s3_abort_idle", 32'(phase), 0);

    // Reset during POS clears every output next cycle.
    start_run(4, 1);
    repeat (227) @(negedge clk);
    check("rst_in_pos", 32'(dbg_state), 32'(POS));
    check("rst_pos_addr0", 32'(pos_rd_addr), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pos_outputs_zero", 32'(all_out_zero()), 1);
    clear_stats(4);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_writes_after", vwr_cnt + pwr_cnt, 0);
    check("rst_idle_after", 32'(dbg_state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
